cordic_txn_driver: RTL

Synthesizable transaction sequencer for the HLS `cordic` top in the `s_pipeline` simulation environment. It drives the DUT's `ap_ctrl_hs` block handshake (`ap_start`/`ap_ready`/`ap_done`) for a fixed number of back-to-back transactions and measures per-transaction latency. When the run completes it raises the `finish` level that the dataflow status monitors sample to end collection and dump their CSVs.

---
 rtl/cordic_txn_pkg.sv | 18 +
 rtl/txn_latency_stats.sv | 42 ++++
 rtl/cordic_txn_driver.sv | 116 +++++++++++
 3 files changed

// File: rtl/cordic_txn_pkg.sv
// Shared types and constants for the cordic ap_ctrl_hs transaction driver.
package cordic_txn_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } txn_state_e;

    // All-ones saturation value for a counter of width w (w <= 64).
    function automatic logic [63:0] LAT_SAT(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/txn_latency_stats.sv
// Run statistics (min/max latency, total run cycles); exists only when
// CORDIC_TXN_DRV_STATS_EN is defined.
`ifdef CORDIC_TXN_DRV_STATS_EN
module txn_latency_stats
    import cordic_txn_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             active,
    input  logic             sample,
    input  logic [CNT_W-1:0] latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] total_cycles
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(LAT_SAT(CNT_W));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_latency  <= SAT;
            max_latency  <= '0;
            total_cycles <= '0;
        end else if (clear) begin
            min_latency  <= SAT;
            max_latency  <= '0;
            total_cycles <= '0;
        end else begin
            if (sample) begin
                if (latency < min_latency) min_latency <= latency;
                if (latency > max_latency) max_latency <= latency;
            end
            if (active && total_cycles != SAT)
                total_cycles <= total_cycles + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/cordic_txn_driver.sv
// ap_ctrl_hs transaction sequencer for the cordic DUT with latency tracking.
// Optional min/max/total statistics: define CORDIC_TXN_DRV_STATS_EN.
module cordic_txn_driver
    import cordic_txn_pkg::*;
#(
    parameter int unsigned NUM_TXN = 16,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned IDX_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_run,
    output logic             dut_ap_start,
    input  logic             dut_ap_ready,
    input  logic             dut_ap_done,
    output logic             busy,
    output logic             finish,
    output logic [IDX_W-1:0] txn_idx,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] total_cycles
);

    localparam logic [CNT_W-1:0] SAT      = CNT_W'(LAT_SAT(CNT_W));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TXN - 1);

    txn_state_e       state;
    logic [CNT_W-1:0] lat_cnt;
    logic             complete;

    // In ISSUE, dut_ap_start low marks the one-cycle gap after a completion.
    assign complete = dut_ap_done &&
                      ((state == ISSUE && dut_ap_start) || state == WAIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dut_ap_start <= 1'b0;
            busy         <= 1'b0;
            finish       <= 1'b0;
            txn_idx      <= '0;
            last_latency <= '0;
            lat_cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_run) begin
                        state        <= ISSUE;
                        dut_ap_start <= 1'b1;
                        busy         <= 1'b1;
                        finish       <= 1'b0;
                        txn_idx      <= '0;
                        lat_cnt      <= CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (!dut_ap_start) begin
                        dut_ap_start <= 1'b1;
                    end else if (!dut_ap_done) begin
                        if (lat_cnt != SAT) lat_cnt <= lat_cnt + 1'b1;
                        if (dut_ap_ready) begin
                            state        <= WAIT;
                            dut_ap_start <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!dut_ap_done && lat_cnt != SAT) lat_cnt <= lat_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (complete) begin
                last_latency <= lat_cnt;
                txn_idx      <= txn_idx + 1'b1;
                dut_ap_start <= 1'b0;
                lat_cnt      <= CNT_W'(1);
                if (txn_idx == LAST_IDX) begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    finish <= 1'b1;
                end else begin
                    state <= ISSUE;
                end
            end
        end
    end

`ifdef CORDIC_TXN_DRV_STATS_EN
    logic launch;
    logic active;

    assign launch = start_run && (state == IDLE || state == DONE);
    assign active = (state == ISSUE) || (state == WAIT);

    txn_latency_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clock        (clock),
        .reset        (reset),
        .clear        (launch),
        .active       (active),
        .sample       (complete),
        .latency      (lat_cnt),
        .min_latency  (min_latency),
        .max_latency  (max_latency),
        .total_cycles (total_cycles)
    );
`else
    assign min_latency  = '0;
    assign max_latency  = '0;
    assign total_cycles = '0;
`endif

endmodule
